bg_scan_reader: RTL and testbench
=================================

BG_SCAN_READER -- requirements
Module: bg_scan_reader

Interface
REQ-001 SHALL have parameter IMG_W, default 700, meaning stored background width in pixels.
REQ-002 SHALL have parameter IMG_H, default 480, meaning stored background height in lines.
REQ-003 SHALL have parameter ADDR_W, default 19, meaning background RAM address width.
REQ-004 Port CLK  input  1  single clock; all logic on posedge.
REQ-005 Port RESET_N  input  1  reset, asynchronous, active-low.
REQ-006 Port frame_start  input  1  one-cycle pulse before first active line of a frame.
REQ-007 Port line_start  input  1  one-cycle pulse before each line's first active pixel.
REQ-008 Port de  input  1  display enable; high means one visible pixel this cycle.
REQ-009 Port scroll_x  input  10  requested horizontal scroll offset in pixels.
REQ-010 Port READ_ADDR  output  ADDR_W  address to background RAM read port.
REQ-011 Port mem_data  input  4  palette index from RAM, valid one cycle after READ_ADDR.
REQ-012 Port red, green, blue  output  8 each  pixel colour.
REQ-013 Port pix_valid  output  1  high when red/green/blue carry a visible pixel.

Function
REQ-014 Address SHALL be row_base + col, with no multiplier; row_base and col are registers.
REQ-015 On frame_start: row_base SHALL clear to 0, line_cnt to 0, and scroll_x SHALL latch into scroll_q if scroll_x < IMG_W; otherwise scroll_q SHALL keep its old value.
REQ-016 scroll_q SHALL change only on frame_start; mid-frame scroll_x changes SHALL have no effect.
REQ-017 On line_start: col SHALL load scroll_q. If this is not the first line_start after frame_start, row_base SHALL add IMG_W and line_cnt SHALL increment.
REQ-018 Each cycle with de=1: col SHALL increment. It SHALL wrap from IMG_W-1 to 0 (horizontal wrap-around).
REQ-019 When line_cnt reaches IMG_H, row_base and line_cnt SHALL saturate. Further lines SHALL re-read line IMG_H-1.
REQ-020 If frame_start and line_start occur in the same cycle, frame_start SHALL act first. The line SHALL then start at row_base=0, col=new scroll_q.
REQ-021 READ_ADDR SHALL present the current pixel's address combinationally from row_base+col during the de cycle.
REQ-022 Pipeline: stage 1 SHALL register de (de_d1). Stage 2 SHALL register the palette lookup of mem_data and de_d1.
REQ-023 Latency SHALL be exactly 2 cycles from the de cycle to pix_valid/RGB.
REQ-024 When the delayed de is 0, red/green/blue SHALL be 0 and pix_valid SHALL be 0.
REQ-025 The palette SHALL be a fixed 16-entry table mapping 4-bit index to 24-bit RGB.
REQ-026 de without a preceding line_start SHALL continue incrementing col. There SHALL be no error state.

Reset
REQ-027 Asserting RESET_N low SHALL immediately clear row_base, col, line_cnt, scroll_q, the pipeline valid bits, red/green/blue and pix_valid to 0.
REQ-028 Reset mid-line SHALL discard in-flight pixels. After release, output SHALL stay black until the next line_start/de.

Structure
REQ-029 The package bg_pkg SHALL hold IMG_W/IMG_H defaults, the rgb_t typedef (3x8-bit struct) and the 16-entry palette constant.
REQ-030 The palette lookup SHALL be one sub-module, bg_palette (index in, rgb_t out, combinational). Its output SHALL be registered in bg_scan_reader.

Verification
REQ-031 Reset, frame_start with scroll_x=0, line_start, 3 de cycles -> READ_ADDR 0,1,2. RGB = palette[mem] appears 2 cycles later with pix_valid=1.
REQ-032 scroll_x=698, frame_start, line_start, 4 de -> READ_ADDR 698,699,0,1.
REQ-033 Second line_start after frame_start with scroll 5 -> first READ_ADDR 705. Third line -> 1405.
REQ-034 scroll_x=700 at frame_start with prior scroll_q=10 -> next line starts at address 10. Changing scroll_x mid-frame -> no change.
REQ-035 481 line_starts in one frame -> line 481 addresses start at 479*700+scroll_q (335300 for scroll 0).
REQ-036 RESET_N low while de high mid-line -> pix_valid and RGB go 0 immediately. After release, with no stimulus, outputs stay 0.

Source files
------------

// File: rtl/bg_pkg.sv
// rtl/bg_pkg.sv - background geometry defaults, pixel colour type and fixed palette
package bg_pkg;

  localparam int BG_IMG_W = 700;
  localparam int BG_IMG_H = 480;

  typedef struct packed {
    logic [7:0] red;
    logic [7:0] green;
    logic [7:0] blue;
  } rgb_t;

  // Classic 16-colour text-mode palette, entry 6 is the brown special case.
  localparam logic [23:0] BG_PALETTE [16] = '{
    24'h000000, 24'h0000AA, 24'h00AA00, 24'h00AAAA,
    24'hAA0000, 24'hAA00AA, 24'hAA5500, 24'hAAAAAA,
    24'h555555, 24'h5555FF, 24'h55FF55, 24'h55FFFF,
    24'hFF5555, 24'hFF55FF, 24'hFFFF55, 24'hFFFFFF
  };

endpackage

// File: rtl/bg_palette.sv
// rtl/bg_palette.sv - combinational 4-bit index to 24-bit colour lookup
module bg_palette
  import bg_pkg::*;
(
  input  logic [3:0] idx,
  output rgb_t       rgb
);

  assign rgb = rgb_t'(BG_PALETTE[idx]);

endmodule

// File: rtl/bg_scan_reader.sv
// rtl/bg_scan_reader.sv - scrolling background scan-out: RAM address generation
// and two-stage palette pipeline to RGB.
module bg_scan_reader
  import bg_pkg::*;
#(
  parameter int IMG_W  = BG_IMG_W,
  parameter int IMG_H  = BG_IMG_H,
  parameter int ADDR_W = 19
) (
  input  logic              CLK,
  input  logic              RESET_N,
  input  logic              frame_start,
  input  logic              line_start,
  input  logic              de,
  input  logic [9:0]        scroll_x,
  output logic [ADDR_W-1:0] READ_ADDR,
  input  logic [3:0]        mem_data,
  output logic [7:0]        red,
  output logic [7:0]        green,
  output logic [7:0]        blue,
  output logic              pix_valid
);

  localparam int LW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam logic [LW-1:0]     LAST_LINE = LW'(IMG_H - 1);
  localparam logic [9:0]        IMG_W_C   = 10'(IMG_W);
  localparam logic [9:0]        COL_MAX   = 10'(IMG_W - 1);
  localparam logic [ADDR_W-1:0] ROW_STEP  = ADDR_W'(IMG_W);

  logic [ADDR_W-1:0] row_base;
  logic [9:0]        col;
  logic [LW-1:0]     line_cnt;
  logic [9:0]        scroll_q;
  logic [9:0]        scroll_next;
  logic              first_line;
  logic              de_d1;
  rgb_t              pal_rgb;
  rgb_t              rgb_q;

  // Out-of-range scroll requests are ignored so the old offset stays in force.
  always_comb begin
    scroll_next = scroll_q;
    if (frame_start && (scroll_x < IMG_W_C)) begin
      scroll_next = scroll_x;
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      row_base   <= '0;
      col        <= '0;
      line_cnt   <= '0;
      scroll_q   <= '0;
      first_line <= 1'b1;
    end else begin
      if (frame_start) begin
        scroll_q   <= scroll_next;
        row_base   <= '0;
        line_cnt   <= '0;
        first_line <= 1'b1;
      end
      if (line_start) begin
        col        <= scroll_next;
        first_line <= 1'b0;
        // A coincident frame_start makes this the first line, so no advance.
        if (!first_line && !frame_start && (line_cnt < LAST_LINE)) begin
          row_base <= row_base + ROW_STEP;
          line_cnt <= line_cnt + 1'b1;
        end
      end else if (de) begin
        col <= (col == COL_MAX) ? 10'd0 : col + 10'd1;
      end
    end
  end

  assign READ_ADDR = row_base + ADDR_W'(col);

  bg_palette u_palette (
    .idx (mem_data),
    .rgb (pal_rgb)
  );

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      de_d1     <= 1'b0;
      pix_valid <= 1'b0;
      rgb_q     <= '0;
    end else begin
      de_d1     <= de;
      pix_valid <= de_d1;
      rgb_q     <= de_d1 ? pal_rgb : '0;
    end
  end

  assign red   = rgb_q.red;
  assign green = rgb_q.green;
  assign blue  = rgb_q.blue;

endmodule

// File: tb/tb_bg_scan_reader.sv
// tb/tb_bg_scan_reader.sv - randomized and directed bench for bg_scan_reader
module tb_bg_scan_reader;

  localparam int IMG_W  = 700;
  localparam int IMG_H  = 480;
  localparam int ADDR_W = 19;

  logic              CLK = 1'b0;
  logic              RESET_N = 1'b0;
  logic              frame_start = 1'b0;
  logic              line_start = 1'b0;
  logic              de = 1'b0;
  logic [9:0]        scroll_x = '0;
  logic [ADDR_W-1:0] READ_ADDR;
  logic [3:0]        mem_data = '0;
  logic [7:0]        red, green, blue;
  logic              pix_valid;

  int n_checks = 0;
  int n_fail   = 0;

  int m_scroll, m_lines, m_lscroll, m_pix;
  logic [24:0] exp_q [$];

  bg_scan_reader #(.IMG_W(IMG_W), .IMG_H(IMG_H), .ADDR_W(ADDR_W)) dut (
    .CLK         (CLK),
    .RESET_N     (RESET_N),
    .frame_start (frame_start),
    .line_start  (line_start),
    .de          (de),
    .scroll_x    (scroll_x),
    .READ_ADDR   (READ_ADDR),
    .mem_data    (mem_data),
    .red         (red),
    .green       (green),
    .blue        (blue),
    .pix_valid   (pix_valid)
  );

  always #5 CLK = ~CLK;

  function automatic logic [3:0] ram_f(input logic [31:0] a);
    return a[3:0] ^ a[7:4] ^ a[11:8];
  endfunction

  always @(posedge CLK) mem_data <= ram_f(32'(READ_ADDR));

  // bit0 blue, bit1 green, bit2 red at 0xAA, bit3 adds 0x55; index 6 has half green.
  function automatic logic [23:0] pal_ref(input logic [3:0] i);
    logic [7:0] lo, r, g, b;
    lo = i[3] ? 8'h55 : 8'h00;
    r = (i[2] ? 8'hAA : 8'h00) + lo;
    g = (i[1] ? 8'hAA : 8'h00) + lo;
    b = (i[0] ? 8'hAA : 8'h00) + lo;
    if (i == 4'd6) g = 8'h55;
    return {r, g, b};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_scroll = 0; m_lines = 0; m_lscroll = 0; m_pix = 0;
    exp_q.delete();
    exp_q.push_back('0);
    exp_q.push_back('0);
  endtask

  function automatic int model_addr();
    int row;
    row = (m_lines == 0) ? 0 : m_lines - 1;
    if (row > IMG_H - 1) row = IMG_H - 1;
    return row * IMG_W + (m_lscroll + m_pix) % IMG_W;
  endfunction

  task automatic model_step(input logic fs, input logic ls, input logic d, input int sx);
    if (fs) begin
      if (sx < IMG_W) m_scroll = sx;
      m_lines = 0;
    end
    if (ls) begin
      if (m_lines <= IMG_H) m_lines++;
      m_lscroll = m_scroll;
      m_pix = 0;
    end else if (d) begin
      m_pix = (m_pix + 1) % IMG_W;
    end
  endtask

  task automatic cyc(input logic fs, input logic ls, input logic d, input logic [9:0] sx);
    logic [24:0] e;
    @(negedge CLK);
    frame_start = fs; line_start = ls; de = d; scroll_x = sx;
    #1;
    if (d) chk("read_addr", 32'(READ_ADDR), 32'(model_addr()));
    e = exp_q.pop_front();
    chk("pix_valid", 32'(pix_valid), 32'(e[24]));
    chk("rgb", 32'({red, green, blue}), 32'(e[23:0]));
    if (d) exp_q.push_back({1'b1, pal_ref(ram_f(32'(model_addr())))});
    else   exp_q.push_back('0);
    model_step(fs, ls, d, int'(sx));
  endtask

  initial begin
    logic fs, ls, d;
    model_reset();
    repeat (3) @(posedge CLK);
    #1;
    chk("rst_addr", 32'(READ_ADDR), 0);
    chk("rst_pix_valid", 32'(pix_valid), 0);
    chk("rst_rgb", 32'({red, green, blue}), 0);
    @(negedge CLK);
    RESET_N = 1'b1;

    // Scroll 0, three pixels.
    cyc(1, 0, 0, 0); cyc(0, 1, 0, 0);
    cyc(0, 0, 1, 0); chk("s0_a0", 32'(READ_ADDR), 0);
    cyc(0, 0, 1, 0); chk("s0_a1", 32'(READ_ADDR), 1);
    cyc(0, 0, 1, 0); chk("s0_a2", 32'(READ_ADDR), 2);
    repeat (3) cyc(0, 0, 0, 0);

    // Horizontal wrap.
    cyc(1, 0, 0, 698); cyc(0, 1, 0, 0);
    cyc(0, 0, 1, 0); chk("wrap_a0", 32'(READ_ADDR), 698);
    cyc(0, 0, 1, 0); chk("wrap_a1", 32'(READ_ADDR), 699);
    cyc(0, 0, 1, 0); chk("wrap_a2", 32'(READ_ADDR), 0);
    cyc(0, 0, 1, 0); chk("wrap_a3", 32'(READ_ADDR), 1);
    repeat (2) cyc(0, 0, 0, 0);

    // Row stepping.
    cyc(1, 0, 0, 5); cyc(0, 1, 0, 0);
    cyc(0, 0, 1, 0); chk("row0", 32'(READ_ADDR), 5);
    cyc(0, 1, 0, 0); cyc(0, 0, 1, 0); chk("row1", 32'(READ_ADDR), 705);
    cyc(0, 1, 0, 0); cyc(0, 0, 1, 0); chk("row2", 32'(READ_ADDR), 1405);

    // Out-of-range and mid-frame scroll are ignored.
    cyc(1, 0, 0, 10); cyc(0, 1, 0, 0); cyc(0, 0, 1, 0);
    cyc(1, 0, 0, 700); cyc(0, 1, 0, 0);
    cyc(0, 0, 1, 0); chk("scroll_oor", 32'(READ_ADDR), 10);
    cyc(0, 0, 1, 3); cyc(0, 1, 0, 3);
    cyc(0, 0, 1, 3); chk("scroll_midframe", 32'(READ_ADDR), 710);

    // Coincident frame_start and line_start.
    cyc(1, 1, 0, 20);
    cyc(0, 0, 1, 0); chk("fs_ls_same", 32'(READ_ADDR), 20);

    // Vertical saturation.
    cyc(1, 0, 0, 0);
    for (int i = 0; i < 481; i++) begin
      cyc(0, 1, 0, 0);
      cyc(0, 0, 1, 0);
    end
    chk("sat_line481", 32'(READ_ADDR), 335300);
    cyc(0, 0, 0, 0);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      fs = ($urandom_range(0, 199) == 0);
      ls = ($urandom_range(0, 39) == 0);
      d  = !ls && ($urandom_range(0, 9) < 7);
      cyc(fs, ls, d, 10'($urandom_range(0, 1023)));
    end
    repeat (3) cyc(0, 0, 0, 0);

    // Reset while a line is in flight.
    cyc(1, 0, 0, 0); cyc(0, 1, 0, 0);
    repeat (4) cyc(0, 0, 1, 0);
    @(negedge CLK);
    frame_start = 1'b0; line_start = 1'b0; de = 1'b1;
    #1;
    chk("pv_before_rst", 32'(pix_valid), 1);
    RESET_N = 1'b0;
    #1;
    chk("midrst_pix_valid", 32'(pix_valid), 0);
    chk("midrst_rgb", 32'({red, green, blue}), 0);
    chk("midrst_addr", 32'(READ_ADDR), 0);
    model_reset();
    @(negedge CLK);
    de = 1'b0;
    RESET_N = 1'b1;
    repeat (6) cyc(0, 0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
